password_update_ctrl: RTL and testbench
=======================================

// Module: password_update_ctrl
// PURPOSE
//  Writer side of the password-check path: owns the stored password register consumed by the checker.
//  Accepts a byte-serial update transaction: old password, then new password.
//  Compares the old password in constant time (no early exit, no data-dependent latency).
//  Commits the new password atomically on match; counts failures and enters a timed lockout.
// PARAMETERS
//  PW_BYTES     2        password length in bytes; bytes are sent MSB byte first
//  MAX_FAIL     3        consecutive failed updates that trigger lockout
//  LOCK_CYCLES  256      lockout duration in clk cycles
//  DEFAULT_PW   16'h5A5A reset value of stored_pw; width 8*PW_BYTES
//  TIMEOUT      64       inter-byte timeout in cycles; used only with PWU_TIMEOUT_EN
// PORTS
//  clk        in   1           single clock, rising edge
//  reset_n    in   1           synchronous, active-low reset
//  start      in   1           begin an update transaction; honoured only in IDLE
//  in_valid   in   1           in_data is valid
//  in_data    in   8           password byte
//  in_ready   out  1           block accepts a byte this cycle
//  stored_pw  out  8*PW_BYTES  current password, fed to the checker
//  done       out  1           1-cycle pulse when a transaction ends
//  ok         out  1           result qualified by done: 1 = committed, 0 = rejected
//  locked     out  1           lockout active
//  fail_cnt   out  $clog2(MAX_FAIL+1)  consecutive failure count
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge, any state, including mid-transaction):
//   stored_pw=DEFAULT_PW; in_ready=0, done=0, ok=0, locked=0, fail_cnt=0.
//   Shadow, diff and index registers are cleared; state goes to IDLE.
//  Handshake: a byte transfers when in_valid & in_ready. in_ready=1 only in OLD and NEW.
//   In all other states in_valid is ignored.
//  FSM states: IDLE, OLD, NEW, COMMIT, LOCK.
//  IDLE: on start, clear shadow, diff and idx, then go to OLD. start is ignored in every other state.
//  OLD: per accepted byte, diff |= in_data ^ stored_pw byte[idx].
//   After PW_BYTES bytes, go to NEW unconditionally. A mismatch is never revealed early.
//  NEW: shift each accepted byte into shadow. After PW_BYTES bytes, go to COMMIT.
//  COMMIT (one cycle): done=1.
//   If diff==0: stored_pw<=shadow, ok=1, fail_cnt<=0, next state IDLE.
//   If diff!=0: ok=0, fail_cnt<=fail_cnt+1; next state LOCK if fail_cnt+1==MAX_FAIL, else IDLE.
//   Shadow and diff are cleared on COMMIT exit.
//  Latency: done is asserted exactly 1 cycle after the last NEW byte is accepted, match or mismatch.
//  stored_pw changes only at the COMMIT edge; the checker never sees a partial value.
//  LOCK: locked=1 for exactly LOCK_CYCLES cycles; start is ignored.
//   On expiry: locked=0, fail_cnt=0, next state IDLE.
//  ok holds its value until the next done. done is 0 in every state except COMMIT.
//  fail_cnt saturates at MAX_FAIL and never wraps.
// CONFIGURATION
//  PWU_TIMEOUT_EN defined:
//   In OLD or NEW, TIMEOUT consecutive cycles with no accepted byte abort the transaction.
//   The abort goes to COMMIT with a forced mismatch: done=1, ok=0, and it counts as a failure.
//  PWU_TIMEOUT_EN undefined: no timer logic; a transaction waits for bytes indefinitely.
// STRUCTURE
//  Package pwu_pkg: state enum (IDLE, OLD, NEW, COMMIT, LOCK), PW_W = 8*PW_BYTES,
//   index width $clog2(PW_BYTES), fail-count width.
//  Sub-module pwu_lock_timer: load/count-down timer with an expired flag.
//   Used for LOCK and, when PWU_TIMEOUT_EN is defined, for the inter-byte timeout.
// TESTING
//  1. Update success: reset, start, bytes 5A 5A 12 34 -> done=1, ok=1 one cycle after the last byte;
//     stored_pw=16'h1234, fail_cnt=0.
//  2. Constant-time mismatch: compare old bytes 00 5A and 5A 00 against 5A 5A ->
//     identical done cycle for both; ok=0, fail_cnt increments, stored_pw unchanged.
//  3. Lockout: 3 bad updates -> locked=1 for exactly 256 cycles, start ignored throughout;
//     then fail_cnt=0 and a good update gives ok=1.
//  4. Handshake and ignores: in_valid toggled with gaps -> only bytes with in_ready=1 are taken;
//     start during NEW and bytes in IDLE have no effect.
//  5. Mid-transaction reset: reset_n=0 during NEW after a prior commit of 1234 ->
//     stored_pw=5A5A, all outputs zero, state IDLE.
//  6. PWU_TIMEOUT_EN: stall 64 cycles in OLD -> done=1, ok=0, fail_cnt=1.

Source files
------------

// File: rtl/pwu_pkg.sv
// Shared definitions for the password update controller.
// Contents: password geometry, failure limit, derived widths and the FSM state type.
// Optional build macro used by the controller: PWU_TIMEOUT_EN (inter-byte timeout).
package pwu_pkg;

    localparam int unsigned PW_BYTES = 2;
    localparam int unsigned MAX_FAIL = 3;
    localparam int unsigned PW_W     = 8 * PW_BYTES;
    localparam int unsigned IDX_W    = (PW_BYTES > 1) ? $clog2(PW_BYTES) : 1;
    localparam int unsigned FAIL_W   = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        StIdle,
        StOld,
        StNew,
        StCommit,
        StLock
    } pwu_state_e;

endpackage

// File: rtl/pwu_lock_timer.sv
// Load / count-down timer with an expired flag.
// Ports:
//   i_clk, i_reset_n : clock and synchronous active-low reset
//   i_load           : load i_load_val (takes priority over i_dec)
//   i_load_val       : value to load
//   i_dec            : decrement by one, stopping at zero
//   o_expired        : count is zero
module pwu_lock_timer #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/password_update_ctrl.sv
// Writer side of the password-check path: owns stored_pw and applies byte-serial
// update transactions (old password, then new password, MSB byte first).
// The old password is compared in constant time; the new one is committed atomically
// on match. Consecutive failures are counted and MAX_FAIL of them trigger a timed lockout.
// Ports:
//   clk, reset_n        : clock and synchronous active-low reset
//   start               : begin a transaction (IDLE only)
//   in_valid, in_data   : byte stream; in_ready high in OLD and NEW only
//   stored_pw           : current password for the checker
//   done, ok            : 1-cycle end-of-transaction pulse and its result (ok held until next done)
//   locked, fail_cnt    : lockout active, consecutive failure count
// Build macro PWU_TIMEOUT_EN: abort OLD/NEW after TIMEOUT cycles without an accepted byte.
module password_update_ctrl
    import pwu_pkg::*;
#(
    parameter int unsigned    LOCK_CYCLES = 256,
    parameter int unsigned    TIMEOUT     = 64,
    parameter logic [PW_W-1:0] DEFAULT_PW = PW_W'(16'h5A5A)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [PW_W-1:0]   stored_pw,
    output logic              done,
    output logic              ok,
    output logic              locked,
    output logic [FAIL_W-1:0] fail_cnt
);

    localparam int unsigned CNT_MAX = (LOCK_CYCLES > TIMEOUT) ? LOCK_CYCLES : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    pwu_state_e        r_state, w_state_next;
    logic [PW_W-1:0]   r_stored_pw, r_shadow;
    logic [7:0]        r_diff;
    logic [IDX_W-1:0]  r_idx;
    logic [FAIL_W-1:0] r_fail;
    logic              r_ok;

    logic              w_accept, w_last, w_abort;
    logic [7:0]        w_ref_byte;
    logic              w_tmr_load, w_tmr_dec, w_tmr_expired;
    logic [CNT_W-1:0]  w_tmr_val;

    assign w_accept   = in_valid & in_ready;
    assign w_last     = (r_idx == IDX_W'(PW_BYTES - 1));
    // Byte idx of the old password lines up with stored_pw byte PW_BYTES-1-idx.
    assign w_ref_byte = 8'(r_stored_pw >> (8 * (PW_BYTES - 1 - int'(r_idx))));

    pwu_lock_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_expired  (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        done         = 1'b0;
        locked       = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_tmr_dec    = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StOld;
`ifdef PWU_TIMEOUT_EN
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(TIMEOUT - 1);
`endif
                end
            end
            StOld, StNew: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (w_last) begin
                        w_state_next = (r_state == StOld) ? StNew : StCommit;
                    end
`ifdef PWU_TIMEOUT_EN
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(TIMEOUT - 1);
                end else if (w_tmr_expired) begin
                    w_abort      = 1'b1;
                    w_state_next = StCommit;
                end else begin
                    w_tmr_dec = 1'b1;
`endif
                end
            end
            StCommit: begin
                done = 1'b1;
                if ((r_diff != '0) && (r_fail == FAIL_W'(MAX_FAIL - 1))) begin
                    w_state_next = StLock;
                    // Count LOCK_CYCLES-1 down to 0 inclusive: LOCK_CYCLES cycles in LOCK.
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = CNT_W'(LOCK_CYCLES - 1);
                end else begin
                    w_state_next = StIdle;
                end
            end
            StLock: begin
                locked = 1'b1;
                if (w_tmr_expired) begin
                    w_state_next = StIdle;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stored_pw <= DEFAULT_PW;
            r_shadow    <= '0;
            r_diff      <= '0;
            r_idx       <= '0;
            r_fail      <= '0;
            r_ok        <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_shadow <= '0;
                        r_diff   <= '0;
                        r_idx    <= '0;
                    end
                end
                StOld: begin
                    if (w_accept) begin
                        // Accumulate every byte: no early exit on mismatch.
                        r_diff <= r_diff | (in_data ^ w_ref_byte);
                        r_idx  <= w_last ? '0 : r_idx + 1'b1;
                    end else if (w_abort) begin
                        r_diff <= '1;
                    end
                end
                StNew: begin
                    if (w_accept) begin
                        r_shadow <= PW_W'({r_shadow, in_data});
                        r_idx    <= w_last ? '0 : r_idx + 1'b1;
                    end else if (w_abort) begin
                        r_diff <= '1;
                    end
                end
                StCommit: begin
                    if (r_diff == '0) begin
                        r_stored_pw <= r_shadow;
                        r_fail      <= '0;
                        r_ok        <= 1'b1;
                    end else begin
                        r_ok <= 1'b0;
                        if (r_fail < FAIL_W'(MAX_FAIL)) begin
                            r_fail <= r_fail + 1'b1;
                        end
                    end
                    r_shadow <= '0;
                    r_diff   <= '0;
                    r_idx    <= '0;
                end
                StLock: begin
                    if (w_tmr_expired) begin
                        r_fail <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stored_pw = r_stored_pw;
    assign fail_cnt  = r_fail;
    // During COMMIT the result is shown directly; afterwards the registered copy holds it.
    assign ok        = (r_state == StCommit) ? (r_diff == '0) : r_ok;

endmodule

// File: tb/tb_password_update_ctrl.sv
// Self-checking bench for password_update_ctrl: a table of directed update transactions,
// hand-written lockout / reset / stall sequences, and randomized transactions checked
// against a behavioural model of the stored password and failure count.
module tb_password_update_ctrl;
    import pwu_pkg::*;

    localparam int unsigned LOCK_CYCLES = 256;
    localparam int unsigned TIMEOUT     = 64;
    localparam logic [PW_W-1:0] DEF_PW  = 16'h5A5A;

    logic              clk = 1'b0;
    logic              reset_n, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, done, ok, locked;
    logic [PW_W-1:0]   stored_pw;
    logic [FAIL_W-1:0] fail_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [PW_W-1:0] m_pw;
    int              m_fail;

    typedef struct {
        logic [PW_W-1:0] old_pw;
        logic [PW_W-1:0] new_pw;
        bit              exp_ok;
        logic [PW_W-1:0] exp_pw;
        int              exp_fail;
    } vec_t;
    vec_t vecs[7];

    password_update_ctrl #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .DEFAULT_PW  (DEF_PW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .stored_pw (stored_pw),
        .done      (done),
        .ok        (ok),
        .locked    (locked),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One byte, optionally preceded by idle gaps; start is raised during gaps as noise.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                start    = 1'($urandom_range(0, 1));
                tick();
            end
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 10) begin
            guard++;
            tick();
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [PW_W-1:0] old_pw, input logic [PW_W-1:0] new_pw,
                           input bit gaps, input bit noise, input int stall,
                           output bit got_ok);
        logic [2*PW_W-1:0] all_bytes;
        bit bad;
        int t0;
        all_bytes = {old_pw, new_pw};
        if (noise) begin
            bad = 1'b0;
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                if (in_ready || done) bad = 1'b1;
                tick();
            end
            in_valid = 1'b0;
            check("idle_bytes_ignored", {31'd0, bad}, 32'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        if (stall > 0) begin
            repeat (stall) tick();
            check("stall_no_done", {31'd0, done}, 32'd0);
            check("stall_ready", {31'd0, in_ready}, 32'd1);
        end
        for (int i = 0; i < 2 * PW_BYTES; i++) begin
            send_byte(all_bytes[8*(2*PW_BYTES-1-i) +: 8], gaps);
        end
        check("done_after_last_byte", {31'd0, done}, 32'd1);
        if (!gaps && stall == 0) check("txn_latency", cyc - t0 - stall, 2 * PW_BYTES);
        got_ok = ok;
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_lock();
        int n;
        bit bad;
        n   = 0;
        bad = 1'b0;
        while (locked && n < 1000) begin
            n++;
            if (in_ready || done) bad = 1'b1;
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("lock_length", n, LOCK_CYCLES);
        check("lock_ignores_inputs", {31'd0, bad}, 32'd0);
        check("lock_fail_cleared", fail_cnt, 0);
        check("lock_pw_kept", stored_pw, m_pw);
        m_fail = 0;
    endtask

    // Reference behaviour: match commits and clears failures, mismatch counts up to lockout.
    task automatic model_apply(input logic [PW_W-1:0] old_pw, input logic [PW_W-1:0] new_pw,
                               input bit got_ok);
        bit exp_ok;
        exp_ok = (old_pw == m_pw);
        check("txn_ok", {31'd0, got_ok}, {31'd0, exp_ok});
        if (exp_ok) begin
            m_pw   = new_pw;
            m_fail = 0;
        end else if (m_fail < int'(MAX_FAIL)) begin
            m_fail++;
        end
        check("txn_ok_held", {31'd0, ok}, {31'd0, exp_ok});
        check("txn_stored_pw", stored_pw, m_pw);
        check("txn_fail_cnt", fail_cnt, m_fail);
        if (m_fail == int'(MAX_FAIL)) begin
            check("lock_entered", {31'd0, locked}, 32'd1);
            wait_lock();
        end
    endtask

    task automatic mid_reset(input int n_bytes, input logic [PW_W-1:0] old_pw);
        logic [2*PW_W-1:0] all_bytes;
        all_bytes = {old_pw, PW_W'(16'hBEEF)};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n_bytes; i++) send_byte(all_bytes[8*(2*PW_BYTES-1-i) +: 8], 1'b0);
        in_valid = 1'b1;
        reset_n  = 1'b0;
        tick();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        check("rst_stored_pw", stored_pw, DEF_PW);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ok", {31'd0, ok}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_fail_cnt", fail_cnt, 0);
        m_pw   = DEF_PW;
        m_fail = 0;
    endtask

    initial begin
        bit              r_ok_got;
        logic [PW_W-1:0] old_v, new_v;

        vecs[0] = '{16'h005A, 16'hFFFF, 1'b0, 16'h5A5A, 1};
        vecs[1] = '{16'h5A00, 16'hFFFF, 1'b0, 16'h5A5A, 2};
        vecs[2] = '{16'h5A5A, 16'h1234, 1'b1, 16'h1234, 0};
        vecs[3] = '{16'h1234, 16'hABCD, 1'b1, 16'hABCD, 0};
        vecs[4] = '{16'h1235, 16'h0000, 1'b0, 16'hABCD, 1};
        vecs[5] = '{16'hABCD, 16'h0000, 1'b1, 16'h0000, 0};
        vecs[6] = '{16'h0000, 16'h5A5A, 1'b1, 16'h5A5A, 0};

        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        check("reset_stored_pw", stored_pw, DEF_PW);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ok", {31'd0, ok}, 32'd0);
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_fail_cnt", fail_cnt, 0);
        reset_n = 1'b1;
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // Directed table: equal latency for mismatch and match, commit and failure counting.
        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].old_pw, vecs[v].new_pw, 1'b0, 1'b0, 0, r_ok_got);
            check("vec_ok", {31'd0, r_ok_got}, {31'd0, vecs[v].exp_ok});
            check("vec_stored_pw", stored_pw, vecs[v].exp_pw);
            check("vec_fail_cnt", fail_cnt, vecs[v].exp_fail);
        end
        m_pw   = 16'h5A5A;
        m_fail = 0;

        // Lockout after MAX_FAIL bad updates, then a good update is accepted.
        for (int k = 0; k < int'(MAX_FAIL); k++) begin
            run_txn(m_pw ^ PW_W'(16'h0100), PW_W'(16'h7777), 1'b0, 1'b0, 0, r_ok_got);
            model_apply(m_pw ^ PW_W'(16'h0100), PW_W'(16'h7777), r_ok_got);
        end
        run_txn(m_pw, PW_W'(16'h2468), 1'b0, 1'b0, 0, r_ok_got);
        model_apply(m_pw, PW_W'(16'h2468), r_ok_got);

        // Gapped handshake, bytes offered in IDLE, start raised mid-transaction.
        for (int k = 0; k < 3; k++) begin
            new_v = PW_W'($urandom);
            run_txn(m_pw, new_v, 1'b1, 1'b1, 0, r_ok_got);
            model_apply(m_pw, new_v, r_ok_got);
        end

        // Reset in NEW with a nonzero fail count, then in OLD after ok=1.
        run_txn(m_pw, PW_W'(16'h1234), 1'b0, 1'b0, 0, r_ok_got);
        model_apply(m_pw, PW_W'(16'h1234), r_ok_got);
        run_txn(PW_W'(16'h0000), PW_W'(16'h9999), 1'b0, 1'b0, 0, r_ok_got);
        model_apply(PW_W'(16'h0000), PW_W'(16'h9999), r_ok_got);
        mid_reset(PW_BYTES + 1, m_pw);
        run_txn(DEF_PW, PW_W'(16'h1234), 1'b0, 1'b0, 0, r_ok_got);
        model_apply(DEF_PW, PW_W'(16'h1234), r_ok_got);
        mid_reset(1, m_pw);
        run_txn(DEF_PW, PW_W'(16'hC0DE), 1'b0, 1'b0, 0, r_ok_got);
        model_apply(DEF_PW, PW_W'(16'hC0DE), r_ok_got);

`ifdef PWU_TIMEOUT_EN
        // Stall in OLD: abort after exactly TIMEOUT idle cycles, counted as a failure.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (TIMEOUT - 1) tick();
        check("timeout_not_early", {31'd0, done}, 32'd0);
        tick();
        check("timeout_done", {31'd0, done}, 32'd1);
        check("timeout_ok", {31'd0, ok}, 32'd0);
        tick();
        m_fail++;
        check("timeout_fail_cnt", fail_cnt, m_fail);
        check("timeout_pw_kept", stored_pw, m_pw);
`else
        // Without the timeout a stalled transaction simply waits.
        run_txn(m_pw, PW_W'(16'h4321), 1'b0, 1'b0, 100, r_ok_got);
        model_apply(m_pw, PW_W'(16'h4321), r_ok_got);
`endif

        // Randomized transactions against the model.
        for (int k = 0; k < 40; k++) begin
            old_v = ($urandom_range(0, 1) == 1) ? m_pw : PW_W'($urandom);
            new_v = PW_W'($urandom);
            run_txn(old_v, new_v, 1'b1, 1'($urandom_range(0, 1)), 0, r_ok_got);
            model_apply(old_v, new_v, r_ok_got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
